// File: rtl/fpu_lsu.sv
// fpu_lsu: single-outstanding FLW/FSW sequencer between FPU decode and the CORE-V-XIF memory interface.
// Latency: 3 cycles from accept to done/writeback (request, result, done), 1 cycle for misaligned addresses.
// Backpressure: ls_ready is high only in IDLE; mem_req is held stable until mem_ready.

package fpu_lsu_pkg;
    localparam int X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           addr;
        logic [1:0]            mode;
        logic                  we;
        logic [2:0]            size;
        logic [3:0]            be;
        logic [1:0]            attr;
        logic [31:0]           wdata;
        logic                  last;
        logic                  spec;
    } x_mem_req_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           rdata;
        logic                  err;
    } x_mem_result_t;
endpackage

module fpu_lsu
    import fpu_lsu_pkg::*;
#(
    // Must match the ID width of the packed memory structs in fpu_lsu_pkg.
    parameter int X_ID_WIDTH  = fpu_lsu_pkg::X_ID_WIDTH,
    // Only 32-bit memory data is supported.
    parameter int X_MEM_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic [X_ID_WIDTH-1:0] ls_id,
    input  logic                  ls_we,
    input  logic [31:0]           ls_addr,
    input  logic [4:0]            ls_rd,
    input  logic [31:0]           ls_wdata,
    input  logic                  ls_kill,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output x_mem_req_t            mem_req,
    input  logic                  mem_result_valid,
    input  x_mem_result_t         mem_result,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  done_valid,
    output logic [X_ID_WIDTH-1:0] done_id,
    output logic                  done_err,
    output logic                  busy
);

    localparam int MW = X_MEM_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [X_ID_WIDTH-1:0] id_q, id_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [4:0]            rd_q, rd_d;
    logic [MW-1:0]         wdata_q, wdata_d;
    logic [MW-1:0]         rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  killed_q, killed_d;

    // Commands are only taken in IDLE, and never while reset is held.
    assign ls_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q != IDLE);

    // State and captured command/result fields; reset drops everything, including an in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            rd_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            killed_q <= killed_d;
        end
    end

    // Next-state logic and outputs; all payload outputs are zero outside the state that drives them.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        killed_d   = killed_q;
        mem_valid  = 1'b0;
        mem_req    = '0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        done_valid = 1'b0;
        done_id    = '0;
        done_err   = 1'b0;

        case (state_q)
            IDLE: begin
                // ls_kill has no meaning here: there is nothing in flight to abort.
                if (ls_valid && ls_ready) begin
                    id_d     = ls_id;
                    we_d     = ls_we;
                    addr_d   = ls_addr;
                    rd_d     = ls_rd;
                    wdata_d  = ls_wdata;
                    rdata_d  = '0;
                    killed_d = 1'b0;
                    if (ls_addr[1:0] != 2'b00) begin
                        // Misaligned word access completes with an error without touching memory.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ;
                    end
                end
            end

            REQ: begin
                mem_valid     = 1'b1;
                mem_req.id    = id_q;
                mem_req.addr  = addr_q;
                mem_req.mode  = 2'b11;
                mem_req.we    = we_q;
                mem_req.size  = 3'b010;
                mem_req.be    = 4'hF;
                mem_req.attr  = 2'b00;
                mem_req.wdata = we_q ? wdata_q : '0;
                mem_req.last  = 1'b1;
                mem_req.spec  = 1'b0;
                if (mem_ready) begin
                    // Request already handed over: a kill now can only suppress the writeback.
                    killed_d = killed_q | ls_kill;
                    state_d  = WAIT;
                end else if (ls_kill) begin
                    state_d = IDLE;
                end
            end

            WAIT: begin
                if (ls_kill) begin
                    killed_d = 1'b1;
                end
                // Results for other IDs belong to someone else and are left alone.
                if (mem_result_valid && (mem_result.id == id_q)) begin
                    rdata_d = mem_result.rdata;
                    err_d   = mem_result.err;
                    state_d = DONE;
                end
            end

            DONE: begin
                done_valid = 1'b1;
                done_id    = id_q;
                done_err   = err_q;
                if (ls_kill) begin
                    killed_d = 1'b1;
                end
                wb_valid = !we_q && !err_q && !killed_q && !ls_kill;
                if (wb_valid) begin
                    wb_rd   = rd_q;
                    wb_data = rdata_q;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpu_lsu.sv
// Scoreboard bench for fpu_lsu: a driver issues commands and plays the memory side,
// pushing the expected completion; a negedge monitor pops and compares on every done pulse.
module tb_fpu_lsu;
    import fpu_lsu_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          ls_valid, ls_ready, ls_we, ls_kill;
    logic [3:0]    ls_id;
    logic [31:0]   ls_addr, ls_wdata;
    logic [4:0]    ls_rd;
    logic          mem_valid, mem_ready, mem_result_valid;
    x_mem_req_t    mem_req;
    x_mem_result_t mem_result;
    logic          wb_valid, done_valid, done_err, busy;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic [3:0]    done_id;

    fpu_lsu #(.X_ID_WIDTH(4), .X_MEM_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_id(ls_id), .ls_we(ls_we),
        .ls_addr(ls_addr), .ls_rd(ls_rd), .ls_wdata(ls_wdata), .ls_kill(ls_kill),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_result_valid(mem_result_valid), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  id;
        bit          err;
        bit          wb;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    bit         req_allowed = 1'b0;
    x_mem_req_t exp_req;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: request payload every cycle, completions against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_valid", mem_valid, req_allowed);
            if (mem_valid && req_allowed) chk("mem_req", mem_req, exp_req);
            if (done_valid) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", done_valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_id", done_id, e.id);
                    chk("done_err", done_err, e.err);
                    chk("wb_valid", wb_valid, e.wb);
                    if (e.wb) begin
                        chk("wb_rd", wb_rd, e.rd);
                        chk("wb_data", wb_data, e.data);
                    end
                end
            end else begin
                chk("wb_without_done", wb_valid, done_valid);
            end
        end
    end

    // kill_mode: 0 none, 1 kill in REQ with mem_ready=0, 2 kill in WAIT, 3 kill in REQ alongside mem_ready.
    task automatic run_txn(input logic [3:0] id, input bit we, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] wdata, input int rdy_dly,
                           input bit wrong, input logic [3:0] wrong_id, input bit same_cyc_res,
                           input bit err, input logic [31:0] rdata, input int kill_mode);
        int acc;
        ls_valid = 1'b1; ls_id = id; ls_we = we; ls_addr = addr; ls_rd = rd; ls_wdata = wdata;
        @(posedge clk); #1;
        acc = cyc;
        ls_valid = 1'b0;
        if (addr[1:0] != 2'b00) begin
            q.push_back('{id, 1'b1, 1'b0, rd, 32'h0, acc});
            @(posedge clk); #1;
            return;
        end
        exp_req = '{id, addr, 2'b11, we, 3'b010, 4'hF, 2'b00, (we ? wdata : 32'h0), 1'b1, 1'b0};
        req_allowed = 1'b1;
        repeat (rdy_dly) begin @(posedge clk); #1; end
        if (kill_mode == 1) begin
            ls_kill = 1'b1;
            @(posedge clk); #1;
            ls_kill = 1'b0;
            req_allowed = 1'b0;
            chk("kill_req_busy", busy, 0);
            chk("kill_req_ready", ls_ready, 1);
            @(posedge clk); #1;
            return;
        end
        mem_ready = 1'b1;
        if (kill_mode == 3) ls_kill = 1'b1;
        if (same_cyc_res) begin
            mem_result_valid = 1'b1;
            mem_result = '{id, ~rdata, ~err};
        end
        @(posedge clk); #1;
        mem_ready = 1'b0; ls_kill = 1'b0; mem_result_valid = 1'b0; req_allowed = 1'b0;
        if (kill_mode == 2) ls_kill = 1'b1;
        if (wrong) begin
            mem_result_valid = 1'b1;
            mem_result = '{wrong_id, ~rdata, 1'b0};
            @(posedge clk); #1;
            ls_kill = 1'b0;
        end
        q.push_back('{id, err, (!we && !err && kill_mode == 0), rd, rdata, cyc + 1});
        mem_result_valid = 1'b1;
        mem_result = '{id, rdata, err};
        @(posedge clk); #1;
        mem_result_valid = 1'b0; ls_kill = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        ls_valid = 0; ls_id = 0; ls_we = 0; ls_addr = 0; ls_rd = 0; ls_wdata = 0; ls_kill = 0;
        mem_ready = 0; mem_result_valid = 0; mem_result = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_rd_data", {wb_rd, wb_data}, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_ls_ready_held", ls_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_ls_ready_after", ls_ready, 1);
        @(posedge clk); #1;

        // Minimum-latency load.
        run_txn(4'd3, 0, 32'h100, 5'd5, 32'h0, 0, 0, 4'd0, 0, 0, 32'h3F800000, 0);
        // Store with three cycles of backpressure.
        run_txn(4'd7, 1, 32'h204, 5'd0, 32'h40490FDB, 3, 0, 4'd0, 0, 0, 32'h12345678, 0);
        // Misaligned.
        run_txn(4'd1, 0, 32'h102, 5'd9, 32'h0, 0, 0, 4'd0, 0, 0, 32'h0, 0);
        // Foreign ID ignored, then error result.
        run_txn(4'd4, 0, 32'h300, 5'd6, 32'h0, 0, 1, 4'd2, 0, 1, 32'hDEADBEEF, 0);
        // Kills: in REQ without ready, in WAIT, in REQ alongside ready.
        run_txn(4'd5, 0, 32'h400, 5'd7, 32'h0, 1, 0, 4'd0, 0, 0, 32'h1, 1);
        run_txn(4'd6, 0, 32'h404, 5'd8, 32'h0, 0, 0, 4'd0, 0, 0, 32'h2, 2);
        run_txn(4'd8, 0, 32'h408, 5'd3, 32'h0, 0, 0, 4'd0, 0, 0, 32'h3, 3);
        // Result presented in the handshake cycle must be ignored.
        run_txn(4'd9, 0, 32'h40C, 5'd4, 32'h0, 2, 0, 4'd0, 1, 0, 32'hCAFEF00D, 0);

        // Reset in WAIT, then a late result for the dropped ID.
        ls_valid = 1; ls_id = 4'd10; ls_we = 0; ls_addr = 32'h500; ls_rd = 5'd2;
        @(posedge clk); #1;
        ls_valid = 0;
        exp_req = '{4'd10, 32'h500, 2'b11, 1'b0, 3'b010, 4'hF, 2'b00, 32'h0, 1'b1, 1'b0};
        req_allowed = 1'b1;
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0; req_allowed = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_valid", mem_valid, 0);
        chk("midrst_done_valid", done_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_ls_ready", ls_ready, 1);
        mem_result_valid = 1; mem_result = '{4'd10, 32'h55AA55AA, 1'b0};
        repeat (2) begin @(posedge clk); #1; end
        mem_result_valid = 0;

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  id, wid;
            logic [31:0] addr;
            int          km, r;
            id   = 4'($urandom_range(0, 15));
            wid  = id + 4'($urandom_range(1, 15));
            addr = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
            if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            r  = $urandom_range(0, 9);
            km = (r < 6) ? 0 : r - 6;
            if ($urandom_range(0, 5) == 0) begin
                // A kill with nothing in flight must be harmless.
                ls_kill = 1;
                @(posedge clk); #1;
                ls_kill = 0;
            end
            run_txn(id, 1'($urandom_range(0, 1)), addr, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), wid,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), $urandom, km);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_lsu.md
FPU_LSU -- requirements
Module: fpu_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter X_ID_WIDTH, default 4: offloaded-instruction ID width.
REQ-003 Parameter X_MEM_WIDTH, default 32: memory data width; only 32 is supported.
REQ-004 Port clk  in  1: clock, rising edge.
REQ-005 Port rst  in  1: asynchronous active-high reset.
REQ-006 Ports ls_valid/ls_ready  in/out  1/1: load/store command handshake from FPU decode.
REQ-007 Port ls_id  in  X_ID_WIDTH: instruction ID.
REQ-008 Port ls_we  in  1: 1 = FSW (store), 0 = FLW (load).
REQ-009 Port ls_addr  in  32: effective address.
REQ-010 Port ls_rd  in  5: FP destination register for loads.
REQ-011 Port ls_wdata  in  32: FP store data.
REQ-012 Port ls_kill  in  1: abort the in-flight command.
REQ-013 Ports mem_valid/mem_ready  out/in  1/1: CORE-V-XIF memory request handshake.
REQ-014 Port mem_req  out  x_mem_req_t: request payload.
REQ-015 Ports mem_result_valid/mem_result  in/in  1/x_mem_result_t: memory result.
REQ-016 Ports wb_valid/wb_rd/wb_data  out  1/5/32: FP register-file write port.
REQ-017 Ports done_valid/done_id/done_err  out  1/X_ID_WIDTH/1: completion pulse.
REQ-018 Port busy  out  1: state is not IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE, and SHALL hold at most one outstanding command.
REQ-020 ls_ready SHALL be 1 only in IDLE; a command is accepted when ls_valid && ls_ready, and its id/we/addr/rd/wdata are registered.
REQ-021 IDLE -> REQ on acceptance with addr[1:0]==0; IDLE -> DONE with err=1 and no memory request when addr[1:0]!=0.
REQ-022 In REQ, mem_valid SHALL be 1, with mem_req fields: id = stored id; addr = stored addr; mode = 2'b11; we = stored we; size = 3'b010; be = 4'hF; attr = 2'b00; wdata = stored wdata for stores and 0 for loads; last = 1; spec = 0.
REQ-023 The mem_req payload SHALL be stable while mem_valid && !mem_ready; REQ -> WAIT on mem_ready.
REQ-024 In WAIT, a result SHALL be consumed only when mem_result_valid && mem_result.id == stored id; a result with a non-matching ID SHALL be ignored; on a matching result WAIT -> DONE, capturing rdata and err.
REQ-025 A result arriving in the same cycle as mem_ready SHALL NOT be consumed; it is sampled from WAIT onward only.
REQ-026 DONE SHALL last exactly one cycle with done_valid=1, done_id = stored id, done_err = captured err, then go to IDLE.
REQ-027 In DONE, wb_valid SHALL be 1 only for a non-killed load with err=0, with wb_rd = stored rd and wb_data = rdata; stores and errored loads SHALL produce no writeback.
REQ-028 ls_kill in REQ while mem_ready=0 SHALL return to IDLE with no done pulse, and mem_valid SHALL drop the next cycle.
REQ-029 ls_kill in REQ while mem_ready=1 SHALL behave as a kill in WAIT, because the request has already been accepted.
REQ-030 ls_kill in WAIT or DONE SHALL set a sticky killed flag: the transaction completes normally with done_valid, but wb_valid is suppressed.
REQ-031 ls_kill in IDLE SHALL be ignored.
REQ-032 Minimum latency: accept at edge N; mem_valid in cycle N+1; with mem_ready in N+1 and a result in N+2, done_valid and wb_valid occur in cycle N+3.
REQ-033 busy SHALL be 1 in REQ, WAIT and DONE.

Reset
REQ-034 On rst, the block SHALL immediately enter IDLE and clear the killed flag and all stored fields.
REQ-035 During and after reset, outputs SHALL be: mem_valid, wb_valid, done_valid, done_err and busy = 0; mem_req, wb_rd, wb_data and done_id = 0; ls_ready = 1 once rst deasserts.
REQ-036 Reset mid-transaction SHALL drop the transaction with no done pulse, and a late result for it SHALL be ignored in IDLE.

Verification
REQ-037 Load: id=3, addr=0x100, rd=5; mem_ready=1 immediately; result id=3, rdata=0x3F800000, err=0 -> mem_req.we=0 and be=F; done_id=3; wb_rd=5 and wb_data=0x3F800000 in cycle N+3.
REQ-038 Store: id=7, addr=0x204, wdata=0x40490FDB; mem_ready held 0 for 3 cycles -> payload stable for 4 cycles; done_valid with done_err=0 and no wb_valid.
REQ-039 Misaligned: addr=0x102 -> mem_valid never asserts; done_valid and done_err=1 the cycle after acceptance; no wb_valid.
REQ-040 Wrong ID/error: in WAIT a result with id=2 is ignored while waiting on id=4; then id=4 with err=1 -> done_err=1 and no wb_valid.
REQ-041 Kill: kill in REQ with mem_ready=0 -> no done pulse and back to IDLE; kill in WAIT -> done_valid=1 and wb_valid=0.
REQ-042 Reset mid-WAIT: assert rst -> busy=0 and mem_valid=0 immediately; a result for the old ID after reset produces no done pulse.
